// File: rtl/rip_lsu.sv
// rip_lsu: RV32I load/store unit with a single-outstanding word-addressed data-memory port.
// Ports: clk/rst_n (sync, active-low); start/inst/addr/wdata issue one access from execute;
// busy/done/rdata/misaligned/fault report status and load data to writeback;
// mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb/mem_ready form the request channel,
// mem_rvalid/mem_rdata the load response channel.
package rip_pkg;
  typedef struct packed {
    logic lb, lh, lw, lbu, lhu, sb, sh, sw;
  } inst_t;
endpackage

module rip_lsu
  import rip_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  inst_t       inst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
  logic [1:0]  state;
  logic [31:0] cnt;
  logic        ld_q, sgn_q;
  logic [1:0]  sz_q, off_q;
  logic        ld, st, n_mis, tmo;
  logic [1:0]  n_sz;
  logic [3:0]  n_strb;
  logic [31:0] n_wd, sh_rd, ld_val;
  assign ld     = inst.lb | inst.lh | inst.lw | inst.lbu | inst.lhu;
  assign st     = inst.sb | inst.sh | inst.sw;
  assign n_sz   = (inst.lw | inst.sw) ? 2'd2 : (inst.lh | inst.lhu | inst.sh) ? 2'd1 : 2'd0;
  assign n_mis  = (n_sz == 2'd2 && addr[1:0] != 2'b00) || (n_sz == 2'd1 && addr[0]);
  assign n_strb = inst.sw ? 4'b1111 : inst.sh ? 4'b0011 << addr[1:0] : inst.sb ? 4'b0001 << addr[1:0] : 4'b0000;
  assign n_wd   = inst.sw ? wdata : inst.sh ? {2{wdata[15:0]}} : inst.sb ? {4{wdata[7:0]}} : 32'h0;
  assign sh_rd  = mem_rdata >> {off_q, 3'b000};
  assign ld_val = sz_q == 2'd2 ? mem_rdata :
                  sz_q == 2'd1 ? {{16{sgn_q & sh_rd[15]}}, sh_rd[15:0]} :
                                 {{24{sgn_q & sh_rd[7]}}, sh_rd[7:0]};
  // The counter's last value before expiry is TIMEOUT_CYCLES-1; completion branches are checked first.
  assign tmo     = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign busy    = state != IDLE;
  assign mem_req = state == REQ;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_q       <= 1'b0;
      sgn_q      <= 1'b0;
      sz_q       <= '0;
      off_q      <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      fault      <= 1'b0;
      rdata      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      fault      <= 1'b0;
      if (state == IDLE) begin
        if (start && (ld || st)) begin
          ld_q      <= ld;
          sgn_q     <= inst.lb | inst.lh;
          sz_q      <= n_sz;
          off_q     <= addr[1:0];
          cnt       <= '0;
          mem_we    <= st;
          mem_addr  <= {addr[31:2], 2'b00};
          mem_wdata <= n_wd;
          mem_wstrb <= n_strb;
          if (n_mis) begin
            done       <= 1'b1;
            misaligned <= 1'b1;
          end else state <= REQ;
        end
      end else begin
        cnt <= cnt + 32'd1;
        if (state == REQ && mem_ready) begin
          state <= ld_q ? RESP : IDLE;
          done  <= !ld_q;
        end else if (state == RESP && mem_rvalid) begin
          state <= IDLE;
          done  <= 1'b1;
          rdata <= ld_val;
        end else if (tmo) begin
          state <= IDLE;
          done  <= 1'b1;
          fault <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rip_lsu.sv
// tb_rip_lsu: directed and randomized checks of rip_lsu against a byte-lane reference model.
module tb_rip_lsu;
  import rip_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, misaligned, fault;
  inst_t       inst;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [3:0]  mem_wstrb;
  int          total = 0, bad = 0;
  logic [31:0] model_rdata = 32'h0;
  localparam int SZ [8] = '{1, 2, 4, 1, 2, 1, 2, 4};

  rip_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_mis"}, misaligned, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_wstrb"}, mem_wstrb, 0);
  endtask

  // index order: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
  function automatic inst_t mk(input int k);
    return inst_t'(8'(8'h80 >> k));
  endfunction

  function automatic logic [31:0] exp_ld(input int k, input logic [31:0] a, input logic [31:0] word);
    int          n = SZ[k];
    logic [31:0] s = word >> (8 * (a % 4));
    longint      m = longint'(1) << (8 * n);
    longint      v;
    if (n == 4) return word;
    v = longint'(s) % m;
    if (k <= 1 && v >= m / 2) v -= m;
    return 32'(v);
  endfunction

  function automatic logic [3:0] exp_strb(input int k, input logic [31:0] a);
    logic [3:0] s = '0;
    if (k < 5) return s;
    for (int j = 0; j < SZ[k]; j++) s[(a % 4) + j] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wd(input int k, input logic [31:0] wd);
    logic [31:0] r = '0;
    if (k < 5) return r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % SZ[k]) +: 8];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] wd,
                        input int rdy, input int rv, input logic [31:0] word);
    bit is_st = k >= 5;
    start = 1'b1; inst = mk(k); addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    if (a % SZ[k] != 0) begin
      chk("mis_done", done, 1);
      chk("mis_flag", misaligned, 1);
      chk("mis_req", mem_req, 0);
      chk("mis_busy", busy, 0);
      chk("mis_rdata", rdata, model_rdata);
      return;
    end
    for (int c = 0; c <= rdy; c++) begin
      if (c > 0) @(negedge clk);
      chk("req", mem_req, 1);
      chk("req_busy", busy, 1);
      chk("req_we", mem_we, 32'(is_st));
      chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("req_wstrb", mem_wstrb, exp_strb(k, a));
      chk("req_wdata", mem_wdata, exp_wd(k, wd));
      chk("req_done", done, 0);
      start = c < rdy ? 1'($urandom % 2) : 1'b0;
      inst = mk($urandom % 8); addr = $urandom; wdata = $urandom;
      mem_ready = c == rdy;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if (!is_st) begin
      chk("resp_req", mem_req, 0);
      chk("resp_busy", busy, 1);
      chk("resp_done", done, 0);
      for (int c = 0; c <= rv; c++) begin
        if (c > 0) @(negedge clk);
        mem_rvalid = c == rv;
        mem_rdata = c == rv ? word : $urandom;
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      model_rdata = exp_ld(k, a, word);
    end
    chk("fin_done", done, 1);
    chk("fin_fault", fault, 0);
    chk("fin_mis", misaligned, 0);
    chk("fin_busy", busy, 0);
    chk("fin_req", mem_req, 0);
    chk("fin_rdata", rdata, model_rdata);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; inst = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_op(7, 32'h1000, 32'hDEADBEEF, 0, 0, 0);
    run_op(5, 32'h1003, 32'h000000A5, 3, 0, 0);
    run_op(0, 32'h2002, 32'h0, 0, 1, 32'h80F17F00);
    chk("lb_val", rdata, 32'hFFFFFFF1);
    run_op(3, 32'h2002, 32'h0, 0, 1, 32'h80F17F00);
    chk("lbu_val", rdata, 32'h000000F1);
    run_op(1, 32'h2002, 32'h0, 0, 1, 32'h80F17F00);
    chk("lh_val", rdata, 32'hFFFF80F1);
    run_op(4, 32'h2002, 32'h0, 0, 1, 32'h80F17F00);
    chk("lhu_val", rdata, 32'h000080F1);
    run_op(2, 32'h2000, 32'h0, 0, 1, 32'h80F17F00);
    chk("lw_val", rdata, 32'h80F17F00);
    run_op(2, 32'h2001, 32'h0, 0, 0, 0);
    run_op(6, 32'h3003, 32'h1234, 0, 0, 0);
    @(negedge clk);
    start = 1'b1; inst = '0; addr = 32'h6000;
    @(negedge clk);
    start = 1'b0;
    chk("noop_busy", busy, 0);
    chk("noop_done", done, 0);
    chk("noop_req", mem_req, 0);
    start = 1'b1; inst = mk(2); addr = 32'h4000;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      chk("tmo_req", mem_req, 1);
      chk("tmo_wait_done", done, 0);
    end
    @(negedge clk);
    chk("tmo_done", done, 1);
    chk("tmo_fault", fault, 1);
    chk("tmo_req_low", mem_req, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_rdata", rdata, model_rdata);
    run_op(7, 32'h4004, 32'hCAFEF00D, 1, 0, 0);
    start = 1'b1; inst = mk(2); addr = 32'h5000;
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rst_resp_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h13572468;
    @(negedge clk);
    mem_rvalid = 1'b0;
    model_rdata = 32'h0;
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rdata", rdata, 0);
    for (int i = 0; i < 60; i++) begin
      int          k = int'($urandom % 8);
      logic [31:0] a = $urandom;
      if ($urandom % 4 != 0) a = a & ~32'(SZ[k] - 1);
      run_op(k, a, $urandom, k >= 5 ? int'($urandom % 4) : int'($urandom % 2),
             int'($urandom % 2), $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
